spi_ram_arbiter: RTL
====================

// Module: spi_ram_arbiter
// PURPOSE
//  Shares the single-port RAM between the SPI slave command stream and a local host port.
//  Decodes SPI commands on rx_data/rx_valid, holds the SPI write and read address registers,
//  and arbitrates round-robin between SPI and host accesses.
//  Returns SPI read data on tx_data/tx_valid and host read data on h_rdata/h_rvalid.
// PARAMETERS
//  ADDR_SIZE  8  RAM address width; rx_data payload width
//  DATA_W     8  RAM word width; tx_data and h_wdata/h_rdata width
// PORTS
//  clk       in   1          rising-edge clock
//  rst_n     in   1          asynchronous, active-low reset
//  rx_data   in   10         SPI command: [9:8] opcode, [7:0] payload
//  rx_valid  in   1          1-cycle strobe; rx_data valid
//  tx_data   out  DATA_W     SPI read data
//  tx_valid  out  1          1-cycle strobe; tx_data valid
//  h_req     in   1          host request, level; held stable until h_gnt
//  h_we      in   1          host access type: 1=write, 0=read
//  h_addr    in   ADDR_SIZE  host address
//  h_wdata   in   DATA_W     host write data
//  h_gnt     out  1          1-cycle pulse; host access issued to RAM this cycle
//  h_rvalid  out  1          1-cycle pulse; h_rdata valid
//  h_rdata   out  DATA_W     host read data
//  ram_en    out  1          RAM access enable
//  ram_we    out  1          RAM write enable, qualified by ram_en
//  ram_addr  out  ADDR_SIZE  RAM address
//  ram_din   out  DATA_W     RAM write data
//  ram_dout  in   DATA_W     RAM read data, valid one cycle after a read with ram_en
//  spi_ovf   out  1          sticky: SPI access command dropped
// BEHAVIOUR
//  Reset (async):
//   - state=IDLE; wr_addr=rd_addr=0; SPI slot empty; last_grant=HOST.
//   - All outputs 0. In-flight reads are discarded; no tx_valid or h_rvalid follows.
//  SPI decode on rx_valid (opcode rx_data[9:8]):
//   - 00: wr_addr<=payload. 10: rd_addr<=payload. Neither uses the slot, and neither can overflow.
//   - 01: load slot {write, wr_addr, payload}.
//   - 11: load slot {read, rd_addr}; payload ignored.
//   - Slot address is captured at decode. A later 00 or 10 does not change a pending slot.
//   - 01 or 11 while the slot is full: command dropped, spi_ovf<=1 until reset.
//   - The slot empties in the GNT_SPI cycle. A 01 or 11 arriving in that same cycle loads the slot and does not overflow.
//  FSM: IDLE, GNT_SPI, GNT_HOST, RD_SPI, RD_HOST.
//   - IDLE: one pending -> its GNT state.
//   - IDLE: both pending -> the side not equal to last_grant.
//   - IDLE: none pending -> stay in IDLE.
//   - GNT_x: ram_en=1, ram_we/ram_addr/ram_din from the granted request; last_grant<=x.
//     GNT_HOST also asserts h_gnt=1.
//     Write -> IDLE. Read -> RD_x.
//   - RD_SPI: tx_data<=ram_dout; tx_valid=1 for 1 cycle; -> IDLE.
//   - RD_HOST: h_rdata<=ram_dout; h_rvalid=1 for 1 cycle; -> IDLE.
//   - ram_en=0 in IDLE and RD_x. ram_we=0 whenever ram_en=0.
//  Latency and throughput:
//   - Pending to ram_en: 1 cycle from the IDLE decision.
//   - Read data: strobe 1 cycle after ram_en.
//   - Occupancy: 2 cycles per write, 3 per read.
//  Host handshake:
//   - Host drops h_req or presents a new request in the cycle after h_gnt.
//   - h_req is sampled only in IDLE, so no double grant.
//  tx_data and h_rdata hold their last value between strobes.
// TESTING
//  1. Reset, then SPI 0x0A5, 0x13C
//     -> GNT_SPI: ram_en=1, ram_we=1, addr 0xA5, din 0x3C. No tx_valid.
//  2. After 1: SPI 0x2A5, 0x300
//     -> ram_en read at 0xA5. Next cycle tx_valid=1, tx_data=0x3C.
//  3. SPI read and host write (0x10<-0x55) pending together after reset
//     -> SPI granted first, host next. Then repeat both -> host first (round-robin).
//  4. Host read 0x10 only, h_req held
//     -> h_gnt one cycle, h_rvalid next cycle with 0x55. No second grant.
//  5. Slot full, host access in progress, SPI 0x1FF arrives
//     -> dropped, spi_ovf=1 and stays 1. A 01 coinciding with GNT_SPI -> accepted, no ovf.
//  6. rst_n low during RD_SPI
//     -> all outputs 0 immediately, no tx_valid afterwards, spi_ovf cleared.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// Shares a single-port RAM between a decoded SPI command stream and a local host port.
// One SPI access slot, round-robin arbitration, one RAM access in flight at a time.
module spi_ram_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           rx_data,
    input  logic                 rx_valid,
    output logic [DATA_W-1:0]    tx_data,
    output logic                 tx_valid,
    input  logic                 h_req,
    input  logic                 h_we,
    input  logic [ADDR_SIZE-1:0] h_addr,
    input  logic [DATA_W-1:0]    h_wdata,
    output logic                 h_gnt,
    output logic                 h_rvalid,
    output logic [DATA_W-1:0]    h_rdata,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [DATA_W-1:0]    ram_din,
    input  logic [DATA_W-1:0]    ram_dout,
    output logic                 spi_ovf
);

    typedef enum logic [2:0] {IDLE, GNT_SPI, GNT_HOST, RD_SPI, RD_HOST} state_t;
    typedef enum logic {SIDE_SPI, SIDE_HOST} side_t;

    state_t               state_q;
    side_t                last_q;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [ADDR_SIZE-1:0] slot_addr_q, slot_addr_d, ram_addr_q;
    logic [DATA_W-1:0]    slot_data_q, slot_data_d, ram_din_q, tx_data_q, h_rdata_q;
    logic                 slot_full_q, slot_full_d, slot_we_q, slot_we_d, ovf_q, ovf_d;
    logic                 ram_en_q, ram_we_q, h_gnt_q, tx_valid_q, h_rvalid_q;
    logic [1:0]           opcode;
    logic [7:0]           payload;
    logic                 grant_spi;

    assign opcode    = rx_data[9:8];
    assign payload   = rx_data[7:0];
    assign grant_spi = slot_full_q && (!h_req || last_q == SIDE_HOST);

    always_comb begin
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        slot_full_d = slot_full_q;
        slot_we_d   = slot_we_q;
        slot_addr_d = slot_addr_q;
        slot_data_d = slot_data_q;
        ovf_d       = ovf_q;
        // Slot frees during GNT_SPI, so a slot command in that cycle reloads it.
        if (state_q == GNT_SPI) slot_full_d = 1'b0;
        if (rx_valid) begin
            case (opcode)
                2'b00: wr_addr_d = ADDR_SIZE'(payload);
                2'b10: rd_addr_d = ADDR_SIZE'(payload);
                default: begin
                    if (slot_full_d) begin
                        ovf_d = 1'b1;
                    end else begin
                        slot_full_d = 1'b1;
                        slot_we_d   = ~opcode[1];
                        slot_addr_d = opcode[1] ? rd_addr_q : wr_addr_q;
                        slot_data_d = opcode[1] ? '0 : DATA_W'(payload);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            slot_full_q <= 1'b0;
            slot_we_q   <= 1'b0;
            slot_addr_q <= '0;
            slot_data_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            slot_full_q <= slot_full_d;
            slot_we_q   <= slot_we_d;
            slot_addr_q <= slot_addr_d;
            slot_data_q <= slot_data_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= SIDE_HOST;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            h_gnt_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            h_rvalid_q <= 1'b0;
            tx_data_q  <= '0;
            h_rdata_q  <= '0;
        end else begin
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            h_gnt_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            h_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_spi) begin
                        state_q    <= GNT_SPI;
                        ram_en_q   <= 1'b1;
                        ram_we_q   <= slot_we_q;
                        ram_addr_q <= slot_addr_q;
                        ram_din_q  <= slot_data_q;
                    end else if (h_req) begin
                        state_q    <= GNT_HOST;
                        ram_en_q   <= 1'b1;
                        ram_we_q   <= h_we;
                        ram_addr_q <= h_addr;
                        ram_din_q  <= h_wdata;
                        h_gnt_q    <= 1'b1;
                    end
                end
                GNT_SPI: begin
                    last_q <= SIDE_SPI;
                    if (ram_we_q) begin
                        state_q <= IDLE;
                    end else begin
                        state_q    <= RD_SPI;
                        tx_valid_q <= 1'b1;
                    end
                end
                GNT_HOST: begin
                    last_q <= SIDE_HOST;
                    if (ram_we_q) begin
                        state_q <= IDLE;
                    end else begin
                        state_q    <= RD_HOST;
                        h_rvalid_q <= 1'b1;
                    end
                end
                RD_SPI: begin
                    tx_data_q <= ram_dout;
                    state_q   <= IDLE;
                end
                RD_HOST: begin
                    h_rdata_q <= ram_dout;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // RAM data is only valid in the strobe cycle: pass it through then, hold the captured copy after.
    assign tx_data  = tx_valid_q ? ram_dout : tx_data_q;
    assign h_rdata  = h_rvalid_q ? ram_dout : h_rdata_q;
    assign tx_valid = tx_valid_q;
    assign h_rvalid = h_rvalid_q;
    assign h_gnt    = h_gnt_q;
    assign ram_en   = ram_en_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign spi_ovf  = ovf_q;

endmodule
